// File: rtl/wb_pkg.sv
// Shared definitions for the writeback scheduler and its scoreboard.
// Optional feature macro: WB_RR_EN (round-robin arbitration between ALU and LSU).
package wb_pkg;

  localparam int WB_XLEN = 32;
  localparam int WB_NREG = 32;
  localparam int WB_AW   = 5;

  // Requester indices into the grant vector.
  localparam int   WB_NREQ = 2;
  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_LSU = 1'b1;

  typedef logic [WB_NREQ-1:0] grant_t;

  // Index of the granted requester; only meaningful when the grant is non-zero.
  function automatic logic grant_idx(grant_t g);
    return g[REQ_LSU] ? REQ_LSU : REQ_ALU;
  endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register busy bits, set at issue and cleared at writeback.
// Register 0 never reads busy. A set and a clear of the same register on
// the same edge leave it set, so a re-issue is never lost.
module wb_scoreboard
  import wb_pkg::*;
#(
  parameter int NREG = WB_NREG,
  parameter int AW   = WB_AW
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic [AW-1:0] rd_addr1,
  input  logic [AW-1:0] rd_addr2,
  output logic          rd_busy1,
  output logic          rd_busy2,
  output logic          any_busy
);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  // Next busy vector: clear first, then set, so set wins on a collision.
  always_comb begin
    busy_nxt = busy;
    if (clr_en) busy_nxt[clr_addr] = 1'b0;
    if (set_en && (set_addr != '0)) busy_nxt[set_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Busy vector register; reset drops every pending write immediately.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) busy <= '0;
    else       busy <= busy_nxt;
  end

  assign rd_busy1 = busy[rd_addr1];
  assign rd_busy2 = busy[rd_addr2];
  assign any_busy = |busy;

endmodule

// File: rtl/wb_scheduler.sv
// Writeback scheduler: arbitrates the single register-file write port between
// the ALU and the LSU, registers the winning write, and keeps the RAW
// scoreboard. Default is fixed priority (LSU wins). Define WB_RR_EN for
// round-robin, where a 1-bit pointer remembers the last winner.
module wb_scheduler
  import wb_pkg::*;
#(
  parameter int XLEN = WB_XLEN,
  parameter int NREG = WB_NREG,
  parameter int AW   = WB_AW
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            issue_en,
  input  logic [AW-1:0]   issue_rd,
  input  logic [AW-1:0]   chk_rs1,
  input  logic [AW-1:0]   chk_rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            write_en,
  output logic [AW-1:0]   write_addr,
  output logic [XLEN-1:0] write_data,
  output logic            all_idle
);

  grant_t          gnt;
  logic [AW-1:0]   win_rd;
  logic [XLEN-1:0] win_data;
  logic            any_busy;

`ifdef WB_RR_EN
  logic last_q;

  // Last-winner pointer; moves only on a transfer. Reset to ALU-last so the
  // LSU takes the first collision.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     last_q <= REQ_ALU;
    else if (|gnt) last_q <= grant_idx(gnt);
  end
`endif

  // Grant selection; ready is held low throughout reset.
  always_comb begin
    gnt = '0;
    if (rstn) begin
`ifdef WB_RR_EN
      if (alu_valid && lsu_valid) begin
        if (last_q == REQ_LSU) gnt[REQ_ALU] = 1'b1;
        else                   gnt[REQ_LSU] = 1'b1;
      end else begin
        gnt[REQ_ALU] = alu_valid;
        gnt[REQ_LSU] = lsu_valid;
      end
`else
      gnt[REQ_LSU] = lsu_valid;
      gnt[REQ_ALU] = alu_valid && !lsu_valid;
`endif
    end
  end

  assign alu_ready = gnt[REQ_ALU];
  assign lsu_ready = gnt[REQ_LSU];
  assign win_rd    = gnt[REQ_LSU] ? lsu_rd   : alu_rd;
  assign win_data  = gnt[REQ_LSU] ? lsu_data : alu_data;

  // Write-port register; a transfer to x0 is consumed without a strobe.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      write_en   <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
    end else if (|gnt) begin
      write_en   <= (win_rd != '0);
      write_addr <= win_rd;
      write_data <= win_data;
    end else begin
      write_en   <= 1'b0;
    end
  end

  wb_scoreboard #(
    .NREG (NREG),
    .AW   (AW)
  ) u_sb (
    .clk      (clk),
    .rstn     (rstn),
    .set_en   (issue_en),
    .set_addr (issue_rd),
    .clr_en   (write_en),
    .clr_addr (write_addr),
    .rd_addr1 (chk_rs1),
    .rd_addr2 (chk_rs2),
    .rd_busy1 (rs1_busy),
    .rd_busy2 (rs2_busy),
    .any_busy (any_busy)
  );

  assign all_idle = !any_busy && !write_en;

endmodule
